// File: rtl/booth_mul_sched_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler.
// The FSM state type and default sizing live here so the top and any future wrappers agree on them.
package booth_mul_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    RESP
  } state_t;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_MUL_CYCLES = 32;
  localparam int unsigned DEF_CNT_W      = $clog2(DEF_MUL_CYCLES);

  // A single-step core still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or above rr_ptr, wrapping around.
// The pointer register belongs to the caller; this block only searches.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_valid
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!any_valid && valid[cand]) begin
        any_valid   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Shares one iterative Booth multiplier between N_REQ requesters: round-robin accept,
// load pulse, fixed step count, result capture, then a tagged valid/ready response.
module booth_mul_scheduler
  import booth_mul_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_result,
  output logic                   busy,
  output logic                   mul_load,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_result
);

  localparam int unsigned CNT_W = cnt_width(MUL_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [2*WIDTH-1:0] result_q;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_valid;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [ID_W-1:0]    ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Gated by reset so nothing is handed over on an edge that discards it.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;

  assign rsp_id     = id_q;
  assign rsp_result = result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      id_q      <= '0;
      result_q  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_load  <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            id_q     <= gnt_idx;
            rr_ptr   <= ptr_next;
            mul_load <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          mul_load <= 1'b0;
          cnt      <= CNT_W'(MUL_CYCLES - 1);
          state    <= RUN;
        end
        RUN: begin
          if (cnt == '0) begin
            state <= CAPT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAPT: begin
          result_q  <= mul_result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mul_load  <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_load_in_load: assert property (@(posedge clk) disable iff (reset) mul_load |-> state == LOAD);

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Scheduler paired with a behavioural radix-2 Booth core; a monitor compares every cycle
// against a transaction-level model (round-robin pick, scoreboard queue, fixed latency).
module tb_booth_mul_scheduler;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 35;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_result;
  logic           busy;
  logic           mul_load;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_result;

  always #5 clk = ~clk;

  booth_mul_scheduler #(
    .N_REQ      (N),
    .WIDTH      (W),
    .MUL_CYCLES (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .mul_load   (mul_load),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result)
  );

  // Radix-2 Booth core: {A(W+1), Q(W), q-1}, one add/sub and arithmetic shift per clock.
  logic [W:0]   bA;
  logic [W-1:0] bQ;
  logic         bq1;
  always @(posedge clk) begin
    logic [W:0] t;
    logic [W:0] m;
    m = {mul_a[W-1], mul_a};
    t = bA;
    if (reset) begin
      bA <= '0; bQ <= '0; bq1 <= 1'b0;
    end else if (mul_load) begin
      bA <= '0; bQ <= mul_b; bq1 <= 1'b0;
    end else begin
      if ({bQ[0], bq1} == 2'b01) t = bA + m;
      else if ({bQ[0], bq1} == 2'b10) t = bA - m;
      {bA, bQ, bq1} <= {t[W], t, bQ};
    end
  end
  assign mul_result = {bA[W-1:0], bQ};

  typedef struct {
    int          id;
    logic [63:0] res;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          n_accept = 0;
  int          m_ptr  = 0;
  logic        m_busy = 1'b0;
  logic        m_load = 1'b0;
  logic [W-1:0] m_a   = '0;
  logic [W-1:0] m_b   = '0;
  logic [N-1:0] sticky    = '0;
  logic [N-1:0] drop_mask = '0;
  logic        rand_ready = 1'b0;
  logic        rst_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    return 64'(sa * sb2);
  endfunction

  always @(posedge clk) rst_q <= reset;

  // Requesters drop valid just after the edge on which they were accepted.
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic         exp_rv;
    int           g;
    int           idx;
    cyc++;
    if (rst_q === 1'b1) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_id", 64'(rsp_id), 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_mul_load", 64'(mul_load), 0);
      chk("rst_mul_a", 64'(mul_a), 0);
      chk("rst_mul_b", 64'(mul_b), 0);
    end
    if (reset) begin
      chk("rst_req_ready", 64'(req_ready), 0);
      sb.delete();
      m_busy = 1'b0; m_load = 1'b0; m_ptr = 0; m_a = '0; m_b = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = (sb.size() > 0) && (cyc >= sb[0].acc + LAT);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("mul_load", 64'(mul_load), 64'(m_load));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        chk("rsp_result", rsp_result, sb[0].res);
      end
      m_load = 1'b0;
      if (exp_rv && rsp_ready) begin
        void'(sb.pop_front());
        m_busy = 1'b0;
      end
      if (g >= 0) begin
        m_a = req_a[g*W +: W];
        m_b = req_b[g*W +: W];
        sb.push_back('{id: g, res: prod(m_a, m_b), acc: cyc});
        m_ptr  = (g + 1) % N;
        m_busy = 1'b1;
        m_load = 1'b1;
        n_accept++;
        if (!sticky[g]) drop_mask[g] = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(sb.size() == 0 && req_valid == '0 && !m_busy) && n < max) begin
      tick;
      n++;
    end
    if (n >= max) timeout("wait_idle");
  endtask

  task automatic wait_accepts(input int target, input int max);
    int n = 0;
    while (n_accept < target && n < max) begin
      tick;
      n++;
    end
    if (n >= max) timeout("wait_accept");
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return '1;
      2:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    post(2, 32'd7, 32'hFFFF_FFFD);
    wait_idle(200);

    do_reset;
    post(0, 32'd12, 32'd34);
    post(1, 32'hFFFF_FF00, 32'd1000);
    post(2, 32'h1234_5678, 32'h9ABC_DEF0);
    post(3, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
    wait_idle(400);

    post(0, 32'h8000_0000, 32'h8000_0000);
    post(1, 32'hFFFF_FFFF, 32'd1);
    post(2, 32'd0, 32'hDEAD_BEEF);
    post(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_idle(400);

    rsp_ready = 1'b0;
    post(1, 32'd1234567, 32'hFFFF_0001);
    n = 0;
    while (!rsp_valid && n < 200) begin tick; n++; end
    if (n >= 200) timeout("bp_rsp");
    post(0, 32'd99, 32'd101);
    repeat (10) tick;
    rsp_ready = 1'b1;
    wait_idle(400);

    do_reset;
    sticky = 4'b0010;
    post(1, 32'd5, 32'hFFFF_FFF9);
    wait_accepts(n_accept + 1, 50);
    repeat (10) tick;
    post(3, 32'd11, 32'd13);
    wait_accepts(n_accept + 2, 300);
    sticky = '0;
    req_valid[1] = 1'b0;
    wait_idle(400);

    post(0, 32'hCAFE_0001, 32'd3);
    n = 0;
    while (!mul_load && n < 50) begin tick; n++; end
    if (n >= 50) timeout("abort_load");
    repeat (10) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    post(0, 32'hFFFF_FFF0, 32'd16);
    post(2, 32'd21, 32'd2);
    wait_idle(400);

    rand_ready = 1'b1;
    repeat (600) begin
      tick;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 9) == 0) post(i, rnd(), rnd());
    end
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    wait_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/booth_mul_scheduler.md
# booth_mul_scheduler

Shares one iterative Booth multiplier core (load-on-pulse, one radix-2 step per cycle, 2×WIDTH product) between N_REQ requesters. Round-robin arbitration over valid/ready request channels; sequences the core (load pulse, fixed step count, result capture); returns the tagged product on a single valid/ready response channel. Sits between client datapaths and the multiplier in the multiplier full-system top.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 32, operand width; product is 2*WIDTH
- MUL_CYCLES, 32, step cycles the core needs after its load cycle
- ID_W, $clog2(N_REQ), response tag width (derived)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_a  in  N_REQ*WIDTH  multiplicand per requester, slice i = [i*WIDTH +: WIDTH], two's complement
- req_b  in  N_REQ*WIDTH  multiplier per requester, same slicing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  ID_W  index of requester that issued the product
- rsp_result  out  2*WIDTH  signed product
- busy  out  1  high in every state except IDLE
- mul_load  out  1  one-cycle load pulse to the core
- mul_a  out  WIDTH  operand to core, registered
- mul_b  out  WIDTH  operand to core, registered
- mul_result  in  2*WIDTH  core product output

## Operation
- FSM: IDLE → LOAD → RUN → CAPT → RESP → IDLE.
- IDLE: if any req_valid, grant g = first valid index searching upward from rr_ptr with wrap. req_ready[g]=1 combinationally in that cycle; on that edge capture req_a/req_b slice g into mul_a/mul_b, g into id_q, rr_ptr ← (g+1) mod N_REQ, go LOAD. No valid: stay, req_ready=0.
- LOAD: mul_load=1 for exactly this cycle; step counter ← MUL_CYCLES−1; go RUN.
- RUN: counter decrements each cycle; leave for CAPT on the edge where counter==0 (exactly MUL_CYCLES RUN cycles).
- CAPT: result_q ← mul_result on ending edge; go RESP.
- RESP: rsp_valid=1, rsp_result=result_q, rsp_id=id_q, all stable; on rsp_valid&&rsp_ready go IDLE.
- mul_a/mul_b held unchanged from accept until next accept (core reads operands combinationally every step).
- req_ready is 0 outside IDLE; requesters hold valid and operands stable until accepted. Non-granted valids stay pending, no loss.
- rr_ptr only advances on a grant; a single requester repeatedly valid is granted every operation.
- Reset (any state, including mid-RUN): state IDLE, rr_ptr=0, counter=0, id_q=0, result_q=0, mul_a=mul_b=0; outputs req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, mul_load=0. In-flight operation discarded, no response.

## Timing
- Accept edge at end of cycle T (req_ready high in T). LOAD in T+1, RUN T+2..T+1+MUL_CYCLES, CAPT T+2+MUL_CYCLES, rsp_valid first high in T+3+MUL_CYCLES (T+35 at default).
- Minimum issue interval MUL_CYCLES+4 cycles (rsp_ready held high).
- rsp_ready low: RESP held indefinitely, outputs stable; pending requests wait.
- Handshake in RESP cycle → IDLE next cycle; earliest next req_ready is that IDLE cycle (no bypass).
- mul_load never asserted during reset or outside LOAD.

## Structure
- Package booth_mul_sched_pkg: state enum (IDLE, LOAD, RUN, CAPT, RESP), default WIDTH/MUL_CYCLES constants, counter width constant $clog2(MUL_CYCLES).
- Sub-module rr_arbiter: combinational N_REQ round-robin pick (inputs valid vector, rr_ptr; outputs one-hot grant, binary index, any_valid). Pointer register stays in the scheduler.
- Bench pairs the scheduler with the real Booth core; mul_load drives the core's load/reset input.

## Test plan
- Single request: req 2 valid, a=7, b=−3 → req_ready[2] one cycle, rsp_valid 35 cycles after accept, rsp_id=2, rsp_result=0xFFFFFFFF_FFFFFFEB.
- All four valid at once, distinct operands, rsp_ready=1 → grant order 0,1,2,3, responses in same order, issue interval 36 cycles, products correct.
- Corner operands: a=b=0x80000000 → 0x40000000_00000000; a=0xFFFFFFFF, b=1 → 0xFFFFFFFF_FFFFFFFF; a=0 → 0.
- Backpressure: rsp_ready low 10 cycles in RESP → rsp_valid/rsp_id/rsp_result stable, no req_ready, mul_load stays 0; release → IDLE next cycle, next grant follows.
- Fairness: req 1 valid continuously, req 3 asserts mid-operation → after req 1's response, req 3 granted next (rr_ptr=2), then req 1.
- Reset asserted in RUN cycle 10 → all outputs 0 next cycle, no rsp_valid for aborted op; fresh request completes correctly with rr_ptr=0.
